adpll_cfg_seq: RTL and testbench
================================

# adpll_cfg_seq

Bus initiator that drives the ADPLL register interface (sel/write/address/data_in/data_out/ready) from the other end. On a start pulse it performs a channel-tune sequence: soft reset, FCW write, mode write, enable write. It then polls the ADPLL_LOCK register until lock or timeout. It sits between the radio MAC/test controller and the ADPLL register block, so channel changes need no CPU involvement.

## Interface
- ADDR_W, `ADPLL_ADDR_W: bus address width
- FCWW, `FCWW (26): frequency control word width
- POLL_GAP, 16: idle cycles between consecutive lock reads (≥1)
- TIMEOUT_CYC, 4096: cycles allowed in poll phase before error
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- start  in  1  single-cycle request to tune; ignored while busy=1
- fcw_in  in  FCWW  channel FCW; sampled on accepted start
- mode_in  in  2  adpll_mode; sampled on accepted start
- sel  out  1  bus select (registered)
- write  out  1  bus write strobe (registered)
- address  out  ADDR_W  bus address (registered)
- data_in  out  32  bus write data (registered), named as seen by the register block
- data_out  in  32  bus read data, combinational on address in the register block
- ready  in  1  register block ready, equal to sel delayed one clk
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at end of sequence (lock or error)
- locked  out  1  last sequence ended in lock; held until next accepted start
- timeout_err  out  1  last sequence timed out; held until next accepted start

## Operation
- States: IDLE, WR_RST, WR_FCW, WR_MODE, WR_EN, POLL_RD, POLL_GAP, FIN.
- IDLE plus start: latch fcw_in/mode_in, clear locked/timeout_err, set busy, go to WR_RST.
- Write states, in order:
  - WR_RST: `ADPLL_SOFT_RST, data 1
  - WR_FCW: `FCW, zero-extended fcw
  - WR_MODE: `ADPLL_MODE, mode
  - WR_EN: `ADPLL_EN, data 1
  - Upper data_in bits are 0.
- The soft reset write restores register defaults. The FCW/mode/en writes after it therefore define the channel.
- POLL_RD: read `ADPLL_LOCK (write=0, data_in=0).
  - data_out[0]=1 → set locked, go to FIN.
  - data_out[0]=0 → go to POLL_GAP, wait POLL_GAP cycles, then go back to POLL_RD.
- Timeout counter clears on entry to the first POLL_RD. It increments every cycle in POLL_RD/POLL_GAP.
  - Reaching TIMEOUT_CYC-1 without lock → set timeout_err, go to FIN.
  - A bus transaction in flight completes first; sel is never dropped before ready.
  - If lock and timeout occur in the same cycle, lock wins.
- FIN: pulse done, clear busy, go to IDLE.
- start during busy is dropped; it is not queued.

## Timing
- Bus transaction (every write and read):
  - Edge E0: sel=1, with address/write/data_in valid.
  - E1: responder sets ready.
  - E2: initiator samples ready=1, registers the read data, and drops sel. address/data_in are held through E2.
  - E3: ready falls.
  - E4: earliest next sel.
- Rule: a new sel is asserted only when sel=0 and ready=0 are both sampled. A transaction therefore takes 4 cycles.
- The responder sees sel&&write on both E1 and E2. Duplicate writes carry the same data and are harmless.
- start at edge S → first sel at S+1. The 4 writes occupy S+1..S+16. The first POLL_RD sel is at S+17.
- A poll iteration on no-lock takes 4 + POLL_GAP cycles.
- done is asserted the cycle after the FIN decision. busy falls together with done.
- Reset (rst=0 at a clk edge) takes effect mid-transaction too. Reset values:
  - sel=0, write=0, address=0, data_in=0
  - busy=0, done=0, locked=0, timeout_err=0
  - state IDLE, counters 0

## Configuration
- ADPLL_CFG_TIMEOUT_EN defined: timeout counter and timeout_err are implemented as above.
- ADPLL_CFG_TIMEOUT_EN undefined:
  - No timeout counter; polling repeats until lock or reset.
  - timeout_err is tied to 0.
  - The TIMEOUT_CYC parameter is unused.

## Test plan
- Nominal tune:
  - Stimulus: fcw_in=26'h2620000, mode_in=2'd1, start; responder model asserts lock after 3 reads.
  - Required: writes seen in order (SOFT_RST=1, FCW=32'h02620000, MODE=1, EN=1); locked=1 and one-cycle done; busy=0.
- Handshake timing: with an immediate-lock responder, check the following.
  - sel high exactly 2 cycles per transaction.
  - 2 idle cycles between transactions.
  - done at S+21.
- Timeout (macro defined, TIMEOUT_CYC=64, lock never set):
  - Required: timeout_err=1, locked=0, done pulse.
  - The last sel falls before FIN; no further bus activity.
- No-timeout build (macro undefined, lock never set):
  - After 10000 cycles: busy=1, timeout_err=0, still polling every 4+POLL_GAP cycles.
- start during busy and in the cycle after done:
  - The first start is ignored.
  - The second start begins a new sequence and clears locked.
- Reset at E1 of the FCW write:
  - The following cycle: sel=0, all outputs 0, state IDLE.
  - A later start reruns the full sequence from WR_RST.

Source files
------------

// File: rtl/adpll_cfg_seq.sv
// adpll_cfg_seq: bus initiator that tunes the ADPLL (soft reset, FCW, mode, enable) and then polls lock.
// Define ADPLL_CFG_TIMEOUT_EN to bound the lock poll with TIMEOUT_CYC and report timeout_err.

`ifndef ADPLL_ADDR_W
`define ADPLL_ADDR_W 8
`endif
`ifndef FCWW
`define FCWW 26
`endif
`ifndef ADPLL_SOFT_RST
`define ADPLL_SOFT_RST 32'h01
`endif
`ifndef FCW
`define FCW 32'h04
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 32'h08
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 32'h0C
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 32'h10
`endif

module adpll_cfg_seq #(
  parameter int ADDR_W      = `ADPLL_ADDR_W,
  parameter int FCWW        = `FCWW,
  parameter int POLL_GAP    = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FCWW-1:0]   fcw_in,
  input  logic [1:0]        mode_in,
  output logic              sel,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_in,
  input  logic [31:0]       data_out,
  input  logic              ready,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              timeout_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR_RST   = 3'd1;
  localparam logic [2:0] S_WR_FCW   = 3'd2;
  localparam logic [2:0] S_WR_MODE  = 3'd3;
  localparam logic [2:0] S_WR_EN    = 3'd4;
  localparam logic [2:0] S_POLL_RD  = 3'd5;
  localparam logic [2:0] S_POLL_GAP = 3'd6;
  localparam logic [2:0] S_FIN      = 3'd7;

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  localparam logic [ADDR_W-1:0] A_SOFT_RST = ADDR_W'(`ADPLL_SOFT_RST);
  localparam logic [ADDR_W-1:0] A_FCW      = ADDR_W'(`FCW);
  localparam logic [ADDR_W-1:0] A_MODE     = ADDR_W'(`ADPLL_MODE);
  localparam logic [ADDR_W-1:0] A_EN       = ADDR_W'(`ADPLL_EN);
  localparam logic [ADDR_W-1:0] A_LOCK     = ADDR_W'(`ADPLL_LOCK);

  logic [2:0]        state_q, state_d;
  logic [FCWW-1:0]   fcw_q, fcw_d;
  logic [1:0]        mode_q, mode_d;
  logic              sel_q, sel_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              locked_q, locked_d;
  logic              rd_done_q, rd_done_d;
  logic              lock_bit_q, lock_bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic              err_set;
  logic              err_clr;
  logic              tcnt_clr;
  logic              to_hit;

  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [2:0]        wr_next;

  // Only bit 0 of the lock register carries information.
  logic unused_rdata;
  assign unused_rdata = ^data_out[31:1];

  always_comb begin
    wr_addr = A_SOFT_RST;
    wr_data = 32'd1;
    wr_next = S_WR_FCW;
    case (state_q)
      S_WR_FCW: begin
        wr_addr = A_FCW;
        wr_data = 32'(fcw_q);
        wr_next = S_WR_MODE;
      end
      S_WR_MODE: begin
        wr_addr = A_MODE;
        wr_data = {30'd0, mode_q};
        wr_next = S_WR_EN;
      end
      S_WR_EN: begin
        wr_addr = A_EN;
        wr_data = 32'd1;
        wr_next = S_POLL_RD;
      end
      default: ;
    endcase
  end

  // A new transaction starts only once both sel and ready are seen low; sel drops on the ready sample.
  always_comb begin
    state_d    = state_q;
    fcw_d      = fcw_q;
    mode_d     = mode_q;
    sel_d      = sel_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    locked_d   = locked_q;
    rd_done_d  = rd_done_q;
    lock_bit_d = lock_bit_q;
    gap_d      = gap_q;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    tcnt_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fcw_d    = fcw_in;
          mode_d   = mode_in;
          locked_d = 1'b0;
          err_clr  = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_WR_RST;
        end
      end
      S_WR_RST, S_WR_FCW, S_WR_MODE, S_WR_EN: begin
        if (sel_q) begin
          if (ready) begin
            sel_d    = 1'b0;
            write_d  = 1'b0;
            state_d  = wr_next;
            tcnt_clr = (state_q == S_WR_EN);
          end
        end else if (!ready) begin
          sel_d   = 1'b1;
          write_d = 1'b1;
          addr_d  = wr_addr;
          wdata_d = wr_data;
        end
      end
      S_POLL_RD: begin
        if (rd_done_q) begin
          rd_done_d = 1'b0;
          if (lock_bit_q) begin
            locked_d = 1'b1;
            state_d  = S_FIN;
          end else if (to_hit) begin
            err_set = 1'b1;
            state_d = S_FIN;
          end else begin
            gap_d   = '0;
            state_d = S_POLL_GAP;
          end
        end else if (sel_q) begin
          if (ready) begin
            sel_d      = 1'b0;
            rd_done_d  = 1'b1;
            lock_bit_d = data_out[0];
          end
        end else if (to_hit) begin
          err_set = 1'b1;
          state_d = S_FIN;
        end else if (!ready) begin
          sel_d   = 1'b1;
          write_d = 1'b0;
          addr_d  = A_LOCK;
          wdata_d = 32'd0;
        end
      end
      S_POLL_GAP: begin
        if (to_hit) begin
          err_set = 1'b1;
          state_d = S_FIN;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_POLL_RD;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fcw_q      <= '0;
      mode_q     <= '0;
      sel_q      <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      locked_q   <= 1'b0;
      rd_done_q  <= 1'b0;
      lock_bit_q <= 1'b0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      fcw_q      <= fcw_d;
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      locked_q   <= locked_d;
      rd_done_q  <= rd_done_d;
      lock_bit_q <= lock_bit_d;
      gap_q      <= gap_d;
    end
  end

`ifdef ADPLL_CFG_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            to_err_q, to_err_d;

  // The counter saturates at its terminal value so a read still in flight can finish first.
  always_comb begin
    tcnt_d = tcnt_q;
    if (tcnt_clr) begin
      tcnt_d = '0;
    end else if ((state_q == S_POLL_RD || state_q == S_POLL_GAP) && tcnt_q != TO_LAST) begin
      tcnt_d = tcnt_q + TO_W'(1);
    end
    to_err_d = to_err_q;
    if (err_clr) begin
      to_err_d = 1'b0;
    end else if (err_set) begin
      to_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt_q   <= '0;
      to_err_q <= 1'b0;
    end else begin
      tcnt_q   <= tcnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign to_hit      = (tcnt_q == TO_LAST);
  assign timeout_err = to_err_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  logic unused_to_ctrl;
  assign unused_to_ctrl = err_set ^ err_clr ^ tcnt_clr;
  assign to_hit         = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign sel     = sel_q;
  assign write   = write_q;
  assign address = addr_q;
  assign data_in = wdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_adpll_cfg_seq.sv
// Randomized self-checking bench for adpll_cfg_seq against a cycle-level model of the tune sequence.
// Builds with or without ADPLL_CFG_TIMEOUT_EN; the lock-never case checks the matching behaviour.

`ifndef ADPLL_SOFT_RST
`define ADPLL_SOFT_RST 32'h01
`endif
`ifndef FCW
`define FCW 32'h04
`endif
`ifndef ADPLL_MODE
`define ADPLL_MODE 32'h08
`endif
`ifndef ADPLL_EN
`define ADPLL_EN 32'h0C
`endif
`ifndef ADPLL_LOCK
`define ADPLL_LOCK 32'h10
`endif

module tb_adpll_cfg_seq;

  localparam int POLL_GAP_TB = 3;
  localparam int TIMEOUT_TB  = 64;
  localparam int ITER        = 4 + POLL_GAP_TB;

  localparam logic [7:0] SOFT_A = 8'(`ADPLL_SOFT_RST);
  localparam logic [7:0] FCW_A  = 8'(`FCW);
  localparam logic [7:0] MODE_A = 8'(`ADPLL_MODE);
  localparam logic [7:0] EN_A   = 8'(`ADPLL_EN);
  localparam logic [7:0] LOCK_A = 8'(`ADPLL_LOCK);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [25:0] fcw_in;
  logic [1:0]  mode_in;
  logic        sel, write;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ready = 1'b0;
  logic        busy, done, locked, timeout_err;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;
  int readCount = 0;
  int lockAfter = 0;
  logic selPrev = 1'b0;

  logic [7:0]  wrAddr[$];
  logic [31:0] wrData[$];
  int          selRise[$];
  int          selFall[$];

  int   sCyc, dCyc, riseSnap;
  bit   gotDone, sawDone;
  logic [25:0] rFcw;
  logic [1:0]  rMode;
  int   rLock;

  adpll_cfg_seq #(
    .ADDR_W(8), .FCWW(26), .POLL_GAP(POLL_GAP_TB), .TIMEOUT_CYC(TIMEOUT_TB)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .fcw_in(fcw_in), .mode_in(mode_in),
    .sel(sel), .write(write), .address(address), .data_in(data_in),
    .data_out(data_out), .ready(ready), .busy(busy), .done(done),
    .locked(locked), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Register-block responder: ready is sel delayed one clock, lock reads report per lockAfter.
  always @(posedge clk) ready <= sel;
  assign data_out = (lockAfter != 0 && readCount >= lockAfter && address == LOCK_A) ? 32'd1 : 32'd0;

  always @(negedge clk) begin
    if (sel && ready) begin
      if (write) begin
        wrAddr.push_back(address);
        wrData.push_back(data_in);
      end else if (address == LOCK_A) begin
        readCount++;
      end
    end
    if (sel && !selPrev) selRise.push_back(cyc);
    if (!sel && selPrev) selFall.push_back(cyc);
    selPrev = sel;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; returns one negedge later with start sampled at edge sOut.
  task automatic startTune(input logic [25:0] f, input logic [1:0] m, input int l, output int sOut);
    wrAddr.delete();
    wrData.delete();
    selRise.delete();
    selFall.delete();
    readCount = 0;
    lockAfter = l;
    fcw_in    = f;
    mode_in   = m;
    start     = 1'b1;
    sOut      = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("startBusy", busy, 1);
    checkOutput("startDone", done, 0);
    checkOutput("startLocked", locked, 0);
    checkOutput("startTimeout", timeout_err, 0);
  endtask

  task automatic waitDone(input int s, input int glitchAt, input int maxCycles, output int dOut, output bit got);
    got  = 1'b0;
    dOut = 0;
    for (int n = 0; n < maxCycles && !got; n++) begin
      if (glitchAt > 0 && cyc + 1 == s + glitchAt) begin
        start  = 1'b1;
        fcw_in = ~fcw_in;
      end
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got  = 1'b1;
        dOut = cyc;
      end
    end
    checkOutput("doneSeen", got, 1);
  endtask

  task automatic verifyTune(input logic [25:0] f, input logic [1:0] m, input int l, input int s, input int d);
    logic [7:0]  ea[4];
    logic [31:0] ed[4];
    ea = '{SOFT_A, FCW_A, MODE_A, EN_A};
    ed = '{32'd1, {6'd0, f}, {30'd0, m}, 32'd1};
    checkOutput("wrCount", wrAddr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < wrAddr.size()) begin
        checkOutput($sformatf("wrAddr%0d", i), 32'(wrAddr[i]), 32'(ea[i]));
        checkOutput($sformatf("wrData%0d", i), wrData[i], ed[i]);
      end
    end
    checkOutput("readCount", readCount, l);
    checkOutput("doneCycle", d - s, 21 + (l - 1) * ITER);
    checkOutput("endLocked", locked, 1);
    checkOutput("endTimeout", timeout_err, 0);
    checkOutput("endBusy", busy, 0);
  endtask

  task automatic applyStimulus(input logic [25:0] f, input logic [1:0] m, input int l, input int glitchAt,
                               output int sOut, output int dOut);
    bit got;
    startTune(f, m, l, sOut);
    waitDone(sOut, glitchAt, 60 + l * ITER, dOut, got);
    verifyTune(f, m, l, sOut, dOut);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; fcw_in = '0; mode_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rstCtrl", {26'd0, sel, write, busy, done, locked, timeout_err}, 0);
    checkOutput("rstAddr", 32'(address), 0);
    checkOutput("rstData", data_in, 0);
    rst = 1'b1;
    @(negedge clk);

    applyStimulus(26'h2620000, 2'd1, 3, 0, sCyc, dCyc);
    @(negedge clk);
    checkOutput("donePulse", done, 0);

    applyStimulus(26'($urandom), 2'($urandom), 1, 0, sCyc, dCyc);
    checkOutput("selRises", selRise.size(), 5);
    checkOutput("selFalls", selFall.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < selRise.size()) checkOutput($sformatf("rise%0d", i), selRise[i] - sCyc, 1 + 4 * i);
      if (i < selFall.size()) checkOutput($sformatf("fall%0d", i), selFall[i] - sCyc, 3 + 4 * i);
    end
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      rFcw  = 26'($urandom);
      rMode = 2'($urandom);
      rLock = $urandom_range(1, 4);
      applyStimulus(rFcw, rMode, rLock, 0, sCyc, dCyc);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    rFcw = 26'($urandom);
    applyStimulus(rFcw, 2'd2, 2, 6, sCyc, dCyc);
    applyStimulus(26'($urandom), 2'd3, 1, 0, sCyc, dCyc);
    @(negedge clk);

    startTune(26'h1234567, 2'd1, 1, sCyc);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstCtrl", {26'd0, sel, write, busy, done, locked, timeout_err}, 0);
    checkOutput("midRstAddr", 32'(address), 0);
    checkOutput("midRstData", data_in, 0);
    checkOutput("midRstWrites", wrAddr.size(), 1);
    rst = 1'b1;
    riseSnap = selRise.size();
    repeat (6) @(negedge clk);
    checkOutput("midRstIdle", selRise.size(), riseSnap);
    applyStimulus(26'h0ABCDEF, 2'd0, 2, 0, sCyc, dCyc);
    @(negedge clk);

`ifdef ADPLL_CFG_TIMEOUT_EN
    startTune(26'($urandom), 2'd1, 0, sCyc);
    waitDone(sCyc, 0, TIMEOUT_TB + 100, dCyc, gotDone);
    checkOutput("toErr", timeout_err, 1);
    checkOutput("toLocked", locked, 0);
    checkOutput("toBusy", busy, 0);
    checkOutput("toSel", sel, 0);
    checkOutput("toWindow", (dCyc - sCyc >= 15 + TIMEOUT_TB - 8) && (dCyc - sCyc <= 15 + TIMEOUT_TB + ITER + 4), 1);
    checkOutput("toLastFall", (selFall.size() > 0) && (selFall[$] < dCyc), 1);
    riseSnap = selRise.size();
    repeat (20) @(negedge clk);
    checkOutput("toQuiet", selRise.size(), riseSnap);
    checkOutput("toErrHeld", timeout_err, 1);
`else
    startTune(26'($urandom), 2'd1, 0, sCyc);
    sawDone = 1'b0;
    repeat (10000) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("ntDone", sawDone, 0);
    checkOutput("ntBusy", busy, 1);
    checkOutput("ntTimeout", timeout_err, 0);
    checkOutput("ntRises", selRise.size() > 100, 1);
    if (selRise.size() >= 2) begin
      checkOutput("ntPeriod", selRise[$] - selRise[$-1], ITER);
      checkOutput("ntRecent", (cyc - selRise[$]) < ITER, 1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
